m_lsu: RTL and testbench
========================

M_LSU -- requirements
Module: m_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles mem_req is held waiting for mem_ack (legal range 1..255).
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  the pipeline has a load or store in the M stage.
REQ-005 SHALL have ports req_we (in, 1, 1=store), req_width (in, 2, `WORD/`HALF/`BYTE from macro.v) and req_sext (in, 1, 1=sign-extend load).
REQ-006 SHALL have ports req_addr (in, 32, byte address) and req_wdata (in, 32, store data, right-justified).
REQ-007 SHALL have port stall  out  1  freezes the pipeline while an access is outstanding.
REQ-008 SHALL have ports rdata (out, 32, aligned and extended load data) and rdata_valid (out, 1, one-cycle pulse when rdata is valid).
REQ-009 SHALL have ports adel, ades and bus_err (out, 1 each): misaligned load, misaligned store, and bus timeout pulses.
REQ-010 SHALL have memory-side outputs mem_req (1), mem_we (1), mem_addr (32, word-aligned), mem_be (4) and mem_wdata (32).
REQ-011 SHALL have memory-side inputs mem_ack (1, access complete) and mem_rdata (32, full word read data).

Function
REQ-012 SHALL implement a state machine with states IDLE, BUSY and RESP.
REQ-013 In IDLE with req_valid high and a legal, aligned request, the block SHALL latch the request and enter BUSY on the next edge.
REQ-014 In BUSY, mem_req SHALL be high and mem_we/mem_addr/mem_be/mem_wdata SHALL stay stable until mem_ack is sampled high.
REQ-015 mem_addr SHALL equal {addr[31:2], 2'b00}.
REQ-016 mem_be SHALL be 4'b1111 for `WORD; 4'b0011 or 4'b1100 by addr[1] for `HALF; and 4'b0001 shifted left by addr[1:0] for `BYTE.
REQ-017 mem_wdata SHALL be wdata for `WORD, {2{wdata[15:0]}} for `HALF and {4{wdata[7:0]}} for `BYTE.
REQ-018 On mem_ack in BUSY, the block SHALL capture the mem_rdata lane selected by addr and width, zero- or sign-extend it per req_sext, and enter RESP.
REQ-019 In RESP, rdata_valid SHALL be 1 for loads only, with rdata held; the block SHALL return to IDLE on the next edge.
REQ-020 stall SHALL equal req_valid AND (state != RESP).
REQ-021 Latency SHALL be ack-cycle + 2 (an immediate ack gives a 3-cycle access).
REQ-022 A cycle counter SHALL start at 0 on entry to BUSY; if TIMEOUT cycles pass with no ack, the block SHALL drop mem_req, enter RESP, pulse bus_err and force rdata to 0.
REQ-023 When mem_ack coincides with the timeout cycle, the ack SHALL win and bus_err SHALL stay 0.
REQ-024 When req_width is not `WORD/`HALF/`BYTE, the block SHALL start no transaction, keep stall low and raise no flags.
REQ-025 mem_ack while not in BUSY SHALL be ignored.

Reset
REQ-026 While reset is low, the block SHALL immediately set state=IDLE and counter=0.
REQ-027 While reset is low, all outputs SHALL be 0, including mem_req and stall (when req_valid is 0); this also applies when reset is asserted mid-access.
REQ-028 After reset is released, the first access SHALL start only from IDLE.

Configuration
REQ-029 With macro M_LSU_ALIGN_CHECK_EN defined, a misaligned `HALF (addr[0]) or `WORD (addr[1:0]!=0) access in IDLE SHALL start no transaction, keep stall low, and give a one-cycle pulse on adel (load) or ades (store).
REQ-030 Without M_LSU_ALIGN_CHECK_EN, the block SHALL ignore addr[0] for `HALF and addr[1:0] for `WORD, and tie adel and ades to 0.

Verification
REQ-031 Word store, addr 0x104, wdata 0xDEADBEEF, ack in the first BUSY cycle -> mem_addr 0x104, mem_be 1111, mem_wdata 0xDEADBEEF, stall high for 2 cycles.
REQ-032 Signed byte load, addr 0x103, mem_rdata 0x80FF1234, ack after 3 cycles -> rdata 0xFFFFFF80 with a single rdata_valid pulse; the unsigned case gives 0x00000080.
REQ-033 Half store, addr 0x22, wdata 0x0000ABCD -> mem_be 1100, mem_wdata 0xABCDABCD, mem_addr 0x20.
REQ-034 No ack with TIMEOUT=4 -> mem_req drops after 4 BUSY cycles, bus_err pulses once and rdata is 0; ack on cycle 4 gives normal completion.
REQ-035 With the macro defined, a word load at 0x102 -> adel pulse, no mem_req and stall low; without the macro -> normal access at 0x100.
REQ-036 reset driven low during BUSY -> mem_req and stall fall immediately without waiting for clk; the next request after release starts a fresh transaction.

Source files
------------

// File: rtl/m_lsu.sv
// m_lsu: load/store unit for the M stage of the pipeline.
//
// Takes one load or store from the pipeline and runs it as a single word
// access on the memory bus. Byte and halfword stores are turned into byte
// enables with the store data copied into every lane. Load data is taken
// from the selected lane and then zero- or sign-extended.
//
// Optional feature: define M_LSU_ALIGN_CHECK_EN to trap misaligned halfword
// and word accesses. A trapped access pulses adel (load) or ades (store) and
// starts no bus access. When the macro is undefined, the low address bits
// that a halfword or word access does not use are ignored, and adel and ades
// are tied to 0.
//
// Parameters
//   TIMEOUT      maximum number of BUSY cycles to wait for mem_ack (1..255)
//
// Ports
//   clk          clock; every state change happens on its rising edge
//   reset        asynchronous reset, active low
//   req_valid    the M stage holds a load or a store
//   req_we       1 = store, 0 = load
//   req_width    `WORD / `HALF / `BYTE; any other code is ignored
//   req_sext     1 = sign-extend the load data
//   req_addr     byte address
//   req_wdata    store data, right-justified
//   stall        holds the pipeline while an access is outstanding
//   rdata        load data, aligned and extended
//   rdata_valid  one-cycle pulse (loads only) while rdata is valid
//   adel, ades   misaligned load / misaligned store pulse
//   bus_err      pulse when no mem_ack arrives within TIMEOUT cycles
//   mem_req      bus request, held high in BUSY
//   mem_we       bus write enable
//   mem_addr     word-aligned bus address
//   mem_be       byte enables
//   mem_wdata    store data copied into the byte lanes
//   mem_ack      access complete; ignored outside BUSY
//   mem_rdata    full-word read data
//   dbg_state    current FSM state, for observation
//
// Handshake: a request is taken in IDLE in the same cycle that req_valid is
// high with a legal width. The pipeline keeps req_valid and the req_* fields
// stable while stall is high. On the bus, mem_req and its attributes stay
// stable from entry to BUSY until the first edge at which mem_ack is sampled
// high (or until the timeout expires). mem_ack completes the access in the
// same cycle; there is no separate ready signal.

`ifndef WORD
`define WORD 2'b00
`endif
`ifndef HALF
`define HALF 2'b01
`endif
`ifndef BYTE
`define BYTE 2'b10
`endif

module m_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        we_q, sext_q, err_q;
  logic [1:0]  width_q, off_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;

  logic        width_ok, misaligned, legal, start, timeout_hit;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // Select the addressed lane of the read word and extend it.
  function automatic logic [31:0] pick_lane(input logic [31:0] w,
                                            input logic [1:0]  width,
                                            input logic [1:0]  off,
                                            input logic        sext);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = off[1] ? w[31:16] : w[15:0];
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (width)
      `HALF:   r = {{16{sext & h[15]}}, h};
      `BYTE:   r = {{24{sext & b[7]}}, b};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    width_ok = 1'b0;
    be_c     = 4'b0000;
    wdata_c  = 32'h0;
    case (req_width)
      `WORD: begin
        width_ok = 1'b1;
        be_c     = 4'b1111;
        wdata_c  = req_wdata;
      end
      `HALF: begin
        width_ok = 1'b1;
        be_c     = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{req_wdata[15:0]}};
      end
      `BYTE: begin
        width_ok = 1'b1;
        be_c     = 4'b0001 << req_addr[1:0];
        wdata_c  = {4{req_wdata[7:0]}};
      end
      default: begin
        width_ok = 1'b0;
      end
    endcase
  end

`ifdef M_LSU_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (req_width == `HALF) misaligned = req_addr[0];
    if (req_width == `WORD) misaligned = (req_addr[1:0] != 2'b00);
  end
`else
  always_comb misaligned = 1'b0;
`endif

  always_comb legal = width_ok & ~misaligned;
  always_comb start = (state == IDLE) & req_valid & legal;

  // The last allowed wait cycle is cnt == TIMEOUT-1. An ack in that same
  // cycle still completes the access normally.
  always_comb timeout_hit = (state == BUSY) & ~mem_ack & (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (mem_ack || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 8'd0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      width_q <= 2'b00;
      off_q   <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (start) begin
        cnt     <= 8'd0;
        we_q    <= req_we;
        sext_q  <= req_sext;
        width_q <= req_width;
        off_q   <= req_addr[1:0];
        addr_q  <= {req_addr[31:2], 2'b00};
        wdata_q <= wdata_c;
        be_q    <= be_c;
        err_q   <= 1'b0;
      end else if (state == BUSY) begin
        if (mem_ack) begin
          rdata_q <= we_q ? 32'h0 : pick_lane(mem_rdata, width_q, off_q, sext_q);
          err_q   <= 1'b0;
        end else if (timeout_hit) begin
          rdata_q <= 32'h0;
          err_q   <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    mem_req     = (state == BUSY);
    mem_we      = (state == BUSY) & we_q;
    mem_addr    = addr_q;
    mem_be      = be_q;
    mem_wdata   = wdata_q;
    rdata       = rdata_q;
    rdata_valid = (state == RESP) & ~we_q;
    bus_err     = (state == RESP) & err_q;
    // Gated by reset so that stall drops as soon as reset goes low. An
    // illegal request in IDLE never stalls.
    stall       = reset & req_valid &
                  ((state == BUSY) | ((state == IDLE) & legal));
    dbg_state   = state;
  end

`ifdef M_LSU_ALIGN_CHECK_EN
  always_comb begin
    adel = reset & (state == IDLE) & req_valid & width_ok & misaligned & ~req_we;
    ades = reset & (state == IDLE) & req_valid & width_ok & misaligned &  req_we;
  end
`else
  always_comb begin
    adel = 1'b0;
    ades = 1'b0;
  end
`endif

endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: checks m_lsu (TIMEOUT=4) using a table of access vectors plus
// hand-written sequences for reset, illegal width, stray ack and alignment.

module tb_m_lsu;

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;
  localparam logic [1:0] W_BAD  = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int         TO     = 4;
  localparam int         NO_ACK = 99;

  logic        clk, reset;
  logic        req_valid, req_we, req_sext;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, adel, ades, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  m_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_width(req_width),
    .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .adel(adel), .ades(ades), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [1:0]  width;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          ack_dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [1:0] width,
                              input logic sext, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] mrd,
                              input int ack_dly, input logic [31:0] e_addr,
                              input logic [3:0] e_be, input logic [31:0] e_wdata,
                              input logic [31:0] e_rdata, input logic e_err,
                              input int e_busy);
    vec_t v;
    v.we = we; v.width = width; v.sext = sext; v.addr = addr;
    v.wdata = wdata; v.mrd = mrd; v.ack_dly = ack_dly; v.e_addr = e_addr;
    v.e_be = e_be; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    v.e_err = e_err; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_we = 1'b0; req_width = W_WORD; req_sext = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  // driver: presents one request and follows it through BUSY and RESP
  task automatic run_vec(input vec_t v);
    int busy;
    int stall_n;
    bit done;
    logic [31:0] exp;
    busy = 0; stall_n = 0; done = 1'b0;
    if (!v.we) exp_q.push_back(v.e_rdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_width = v.width; req_sext = v.sext;
    req_addr = v.addr; req_wdata = v.wdata;
    for (int c = 0; c < 4 * TO + 8 && !done; c++) begin
      #1;
      if (stall) stall_n++;
      if (dbg_state == S_BUSY) begin
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_we", 32'(mem_we), 32'(v.we));
        chk("mem_addr", mem_addr, v.e_addr);
        chk("mem_be", 32'(mem_be), 32'(v.e_be));
        chk("mem_wdata", mem_wdata, v.e_wdata);
        mem_ack = (busy == v.ack_dly);
        mem_rdata = v.mrd;
        busy++;
      end else if (dbg_state == S_RESP) begin
        mem_ack = 1'b0;
        done = 1'b1;
        chk("resp_mem_req", 32'(mem_req), 32'd0);
        chk("resp_stall", 32'(stall), 32'd0);
        chk("bus_err", 32'(bus_err), 32'(v.e_err));
        chk("busy_cycles", 32'(busy), 32'(v.e_busy));
        chk("stall_cycles", 32'(stall_n), 32'(v.e_busy + 1));
        if (!v.we) begin
          exp = exp_q.pop_front();
          chk("rdata", rdata, exp);
          if (!v.e_err) chk("rdata_valid", 32'(rdata_valid), 32'd1);
        end else begin
          chk("store_rdata_valid", 32'(rdata_valid), 32'd0);
        end
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL resp_timeout: no RESP state seen for addr %h", v.addr);
      req_valid = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("after_state", 32'(dbg_state), 32'(S_IDLE));
    chk("after_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("after_bus_err", 32'(bus_err), 32'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    #12;
    // reset state
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_flags", {30'd0, adel, ades}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    //        we    width   sx    addr          wdata         mem_rdata     ack     e_addr        be       e_wdata       e_rdata       err   busy
    vecs.push_back(mk(1'b1, W_WORD, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        0,      32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 1));
    vecs.push_back(mk(1'b0, W_BYTE, 1'b1, 32'h0000_0103, 32'h0,         32'h80FF_1234, 2,      32'h0000_0100, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0, 3));
    vecs.push_back(mk(1'b0, W_BYTE, 1'b0, 32'h0000_0103, 32'h0,         32'h80FF_1234, 2,      32'h0000_0100, 4'b1000, 32'h0,         32'h0000_0080, 1'b0, 3));
    vecs.push_back(mk(1'b1, W_HALF, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 32'h0,        0,      32'h0000_0020, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0, 1));
    vecs.push_back(mk(1'b0, W_HALF, 1'b1, 32'h0000_0020, 32'h0,         32'h1234_8001, 1,      32'h0000_0020, 4'b0011, 32'h0,         32'hFFFF_8001, 1'b0, 2));
    vecs.push_back(mk(1'b0, W_HALF, 1'b0, 32'h0000_0022, 32'h0,         32'h8001_7FFF, 0,      32'h0000_0020, 4'b1100, 32'h0,         32'h0000_8001, 1'b0, 1));
    vecs.push_back(mk(1'b0, W_BYTE, 1'b1, 32'h0000_0101, 32'h0,         32'h0000_7F00, 0,      32'h0000_0100, 4'b0010, 32'h0,         32'h0000_007F, 1'b0, 1));
    vecs.push_back(mk(1'b1, W_BYTE, 1'b0, 32'h0000_0206, 32'h1234_56A5, 32'h0,        1,      32'h0000_0204, 4'b0100, 32'hA5A5_A5A5, 32'h0,        1'b0, 2));
    vecs.push_back(mk(1'b0, W_WORD, 1'b0, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 1,      32'h0000_0300, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0, 2));
    vecs.push_back(mk(1'b0, W_WORD, 1'b0, 32'h0000_0400, 32'h0,         32'hFFFF_FFFF, NO_ACK, 32'h0000_0400, 4'b1111, 32'h0,         32'h0,        1'b1, 4));
    vecs.push_back(mk(1'b0, W_WORD, 1'b0, 32'h0000_0404, 32'h0,         32'h1122_3344, 3,      32'h0000_0404, 4'b1111, 32'h0,         32'h1122_3344, 1'b0, 4));
    vecs.push_back(mk(1'b1, W_WORD, 1'b0, 32'h0000_0408, 32'h0BAD_F00D, 32'h0,        NO_ACK, 32'h0000_0408, 4'b1111, 32'h0BAD_F00D, 32'h0,        1'b1, 4));
`ifndef M_LSU_ALIGN_CHECK_EN
    vecs.push_back(mk(1'b0, W_WORD, 1'b0, 32'h0000_0102, 32'h0,         32'h55AA_55AA, 0,      32'h0000_0100, 4'b1111, 32'h0,         32'h55AA_55AA, 1'b0, 1));
    vecs.push_back(mk(1'b1, W_HALF, 1'b0, 32'h0000_0023, 32'h0000_1357, 32'h0,        0,      32'h0000_0020, 4'b1100, 32'h1357_1357, 32'h0,        1'b0, 1));
`endif

    foreach (vecs[i]) run_vec(vecs[i]);

    // illegal width: no transaction, no stall, no flags
    @(negedge clk);
    req_valid = 1'b1; req_width = W_BAD; req_addr = 32'h0000_0100; req_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bad_stall", 32'(stall), 32'd0);
      chk("bad_mem_req", 32'(mem_req), 32'd0);
      chk("bad_state", 32'(dbg_state), 32'(S_IDLE));
      chk("bad_flags", {29'd0, adel, ades, bus_err}, 32'd0);
      @(negedge clk);
    end
    idle_inputs();

    // stray ack outside BUSY is ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    chk("stray_state", 32'(dbg_state), 32'(S_IDLE));
    chk("stray_rdata_valid", 32'(rdata_valid), 32'd0);
    mem_ack = 1'b0;

`ifdef M_LSU_ALIGN_CHECK_EN
    // misaligned word load and half store are trapped
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_width = W_WORD; req_addr = 32'h0000_0102;
    #1;
    chk("adel", 32'(adel), 32'd1);
    chk("adel_ades", 32'(ades), 32'd0);
    chk("adel_stall", 32'(stall), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("adel_mem_req", 32'(mem_req), 32'd0);
    chk("adel_state", 32'(dbg_state), 32'(S_IDLE));
    chk("adel_drop", 32'(adel), 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_width = W_HALF; req_addr = 32'h0000_0021;
    #1;
    chk("ades", 32'(ades), 32'd1);
    chk("ades_adel", 32'(adel), 32'd0);
    chk("ades_stall", 32'(stall), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("ades_mem_req", 32'(mem_req), 32'd0);
    chk("ades_state", 32'(dbg_state), 32'(S_IDLE));
`endif

    // reset asserted mid-access, away from any clock edge
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_width = W_WORD; req_addr = 32'h0000_0500;
    @(negedge clk); @(negedge clk);
    #1;
    chk("mid_busy", 32'(dbg_state), 32'(S_BUSY));
    chk("mid_mem_req", 32'(mem_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("mid_rst_rdata", rdata, 32'h0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    // fresh transaction: counter restarts, so the ack arrives well before timeout
    run_vec(mk(1'b0, W_WORD, 1'b0, 32'h0000_0600, 32'h0, 32'h600D_D00D, 2,
               32'h0000_0600, 4'b1111, 32'h0, 32'h600D_D00D, 1'b0, 3));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
